// File: rtl/cpu_mem_arbiter_if.sv
// rtl/cpu_mem_arbiter_if.sv - IF/MEM/MMU signal bundle for cpu_mem_arbiter; dmem_misaligned exists only with CPU_MEM_ARB_MISALIGN_EN
interface cpu_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // IF stage
  logic                  if_flush;
  logic [ADDR_WIDTH-1:0] if_flush_pc;
  logic                  if_instr_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_instr_pc;
  logic                  if_instr_ready;
  // MEM stage
  logic                  dmem_req;
  logic                  dmem_write;
  logic                  dmem_signed;
  logic [1:0]            dmem_width;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_done;
  logic [DATA_WIDTH-1:0] dmem_rdata;
`ifdef CPU_MEM_ARB_MISALIGN_EN
  logic                  dmem_misaligned;
`endif
  // MMU port
  logic                  mmu_read_enable;
  logic                  mmu_write_enable;
  logic                  mmu_mem_signed_read;
  logic [1:0]            mmu_mem_data_width;
  logic [ADDR_WIDTH-1:0] mmu_address;
  logic [DATA_WIDTH-1:0] mmu_data_in;
  logic                  mmu_mem_ready;
  logic [DATA_WIDTH-1:0] mmu_data_out;

  // Arbiter side
  modport master (
    input  if_flush, if_flush_pc, if_instr_ready,
    input  dmem_req, dmem_write, dmem_signed, dmem_width, dmem_addr, dmem_wdata,
    input  mmu_mem_ready, mmu_data_out,
`ifdef CPU_MEM_ARB_MISALIGN_EN
    output dmem_misaligned,
`endif
    output if_instr_valid, if_instr, if_instr_pc,
    output dmem_done, dmem_rdata,
    output mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    output mmu_mem_data_width, mmu_address, mmu_data_in
  );

  // Core and MMU side
  modport slave (
    output if_flush, if_flush_pc, if_instr_ready,
    output dmem_req, dmem_write, dmem_signed, dmem_width, dmem_addr, dmem_wdata,
    output mmu_mem_ready, mmu_data_out,
`ifdef CPU_MEM_ARB_MISALIGN_EN
    input  dmem_misaligned,
`endif
    input  if_instr_valid, if_instr, if_instr_pc,
    input  dmem_done, dmem_rdata,
    input  mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
    input  mmu_mem_data_width, mmu_address, mmu_data_in
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - IF prefetch queue plus MEM-stage arbiter on one MMU port; option CPU_MEM_ARB_MISALIGN_EN
module cpu_mem_arbiter #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    FETCH_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input logic               clk,
  input logic               reset,
  cpu_mem_arbiter_if.master bus
);
  localparam int         PTR_W      = $clog2(FETCH_DEPTH);
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  discard_q, discard_d;
  logic                  req_write_q, req_signed_q;
  logic [1:0]            req_width_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PTR_W:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] q_instr_q [FETCH_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_q    [FETCH_DEPTH];

  logic q_valid, q_full, fetch_done, push, pop, misalign_hit;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign q_valid    = (wptr_q != rptr_q);
  assign q_full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign fetch_done = (state_q == FETCH) && bus.mmu_mem_ready;
  // A flush arriving in the completing cycle also drops the result
  assign push       = fetch_done && !discard_q && !bus.if_flush;
  assign pop        = q_valid && bus.if_instr_ready && !bus.if_flush;

`ifdef CPU_MEM_ARB_MISALIGN_EN
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  logic misalign_q;
  assign misalign_hit = ((bus.dmem_width == WIDTH_HALF) && bus.dmem_addr[0]) ||
                        ((bus.dmem_width == WIDTH_WORD) && (bus.dmem_addr[1:0] != 2'b00));

  // Remember whether the DONE being entered is a misalignment rejection
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (state_q == IDLE) begin
      misalign_q <= bus.dmem_req && misalign_hit;
    end
  end
`else
  assign misalign_hit = 1'b0;
`endif

  // State and control registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      fetch_addr_q <= '0;
      discard_q    <= 1'b0;
      rdata_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      req_write_q  <= 1'b0;
      req_signed_q <= 1'b0;
      req_width_q  <= 2'b00;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      rdata_q      <= rdata_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      if ((state_q == IDLE) && bus.dmem_req) begin
        req_write_q  <= bus.dmem_write;
        req_signed_q <= bus.dmem_signed;
        req_width_q  <= bus.dmem_width;
        req_addr_q   <= bus.dmem_addr;
        req_wdata_q  <= bus.dmem_wdata;
      end
    end
  end

  // Queue storage needs no reset: entries are only observed behind the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_q[wptr_q[PTR_W-1:0]] <= bus.mmu_data_out;
      q_pc_q[wptr_q[PTR_W-1:0]]    <= fetch_addr_q;
    end
  end

  // Next state: data beats fetch in IDLE, and an access runs to completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.dmem_req) begin
          state_d = misalign_hit ? DONE : DATA;
        end else if (!q_full && !bus.if_flush) begin
          state_d = FETCH;
        end
      end
      FETCH:   if (bus.mmu_mem_ready) state_d = IDLE;
      DATA:    if (bus.mmu_mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch address, discard flag, load result and queue pointer updates
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    fetch_addr_d = fetch_addr_q;
    discard_d    = discard_q;
    rdata_d      = rdata_q;
    wptr_d       = wptr_q + {{PTR_W{1'b0}}, push};
    rptr_d       = rptr_q + {{PTR_W{1'b0}}, pop};
    if ((state_q == IDLE) && (state_d == FETCH)) begin
      fetch_addr_d = fetch_pc_q;
    end
    if (fetch_done) begin
      discard_d = 1'b0;
      if (!discard_q) begin
        fetch_pc_d = fetch_addr_q + ADDR_WIDTH'(4);
      end
    end
    if (bus.if_flush) begin
      fetch_pc_d = bus.if_flush_pc;
      wptr_d     = '0;
      rptr_d     = '0;
      // The MMU address stays on fetch_addr_q; only its result is dropped
      if ((state_q == FETCH) && !bus.mmu_mem_ready) begin
        discard_d = 1'b1;
      end
    end
    if ((state_q == DATA) && bus.mmu_mem_ready && !req_write_q) begin
      rdata_d = bus.mmu_data_out;
    end
  end

  // Outputs decoded from the registered state and latched fields only
  always_comb begin
    bus.mmu_read_enable     = 1'b0;
    bus.mmu_write_enable    = 1'b0;
    bus.mmu_mem_signed_read = req_signed_q;
    bus.mmu_mem_data_width  = req_width_q;
    bus.mmu_address         = '0;
    bus.mmu_data_in         = '0;
    bus.dmem_done           = 1'b0;
    bus.dmem_rdata          = rdata_q;
    bus.if_instr_valid      = q_valid;
    bus.if_instr            = q_instr_q[rptr_q[PTR_W-1:0]];
    bus.if_instr_pc         = q_pc_q[rptr_q[PTR_W-1:0]];
`ifdef CPU_MEM_ARB_MISALIGN_EN
    bus.dmem_misaligned     = misalign_q && (state_q == DONE);
`endif
    case (state_q)
      FETCH: begin
        bus.mmu_read_enable     = 1'b1;
        bus.mmu_mem_signed_read = 1'b0;
        bus.mmu_mem_data_width  = WIDTH_WORD;
        bus.mmu_address         = fetch_addr_q;
      end
      DATA: begin
        bus.mmu_read_enable  = !req_write_q;
        bus.mmu_write_enable = req_write_q;
        bus.mmu_address      = req_addr_q;
        bus.mmu_data_in      = req_write_q ? req_wdata_q : '0;
      end
      DONE:    bus.dmem_done = 1'b1;
      default: ;
    endcase
  end
endmodule
